// File: rtl/wb_arbiter_if.sv
// Bundle of the ALU result, load-return and register-file write signals around the
// write-back arbiter. The arbiter uses the slave view; producers and consumers use master.
interface wb_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                   alu_valid;
  logic [4:0]             alu_rd;
  logic [XLEN-1:0]        alu_data;
  logic                   ld_valid;
  logic                   ld_ready;
  logic [4:0]             ld_rd;
  logic [XLEN-1:0]        ld_data;
  logic                   wb_en;
  logic [XLEN-1:0]        wb_data;
  logic [4:0]             rd_index;
  logic [31:0]            pend_mask;
  logic [$clog2(DEPTH):0] fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  ld_ready, wb_en, wb_data, rd_index, pend_mask, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output ld_ready, wb_en, wb_data, rd_index, pend_mask, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the unstallable ALU result path with a FIFO of returned
// loads onto the single register-file write port, and exports a mask of queued rds.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [4:0]      fifo_rd   [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;

  logic            alu_sel;
  logic            ld_ready;
  logic            push;
  logic            pop;
  logic [PW-1:0]   offs;
  logic [31:0]     pend_mask;

  logic            wb_en_p1;
  logic [XLEN-1:0] wb_data_p1;
  logic [4:0]      rd_index_p1;

  // x0 writes are architecturally dead: an ALU op to x0 is idle, a load to x0 is
  // acknowledged but never queued.
  assign alu_sel  = bus.alu_valid && (bus.alu_rd != 5'd0);
  assign ld_ready = rst_n && (count < CW'(DEPTH));
  assign push     = bus.ld_valid && ld_ready && (bus.ld_rd != 5'd0);
  assign pop      = !alu_sel && (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[tail] <= bus.ld_data;
      fifo_rd[tail]   <= bus.ld_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry i is live when its distance from head (mod DEPTH) is below the count.
  always_comb begin
    pend_mask = '0;
    offs      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - head;
      if (CW'(offs) < count) pend_mask[fifo_rd[i]] = 1'b1;
    end
  end

  // ---- p1: registered write-back port ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_en_p1    <= 1'b0;
      wb_data_p1  <= '0;
      rd_index_p1 <= '0;
    end else if (alu_sel) begin
      wb_en_p1    <= 1'b1;
      wb_data_p1  <= bus.alu_data;
      rd_index_p1 <= bus.alu_rd;
    end else if (pop) begin
      wb_en_p1    <= 1'b1;
      wb_data_p1  <= fifo_data[head];
      rd_index_p1 <= fifo_rd[head];
    end else begin
      wb_en_p1    <= 1'b0;
    end
  end

  assign bus.ld_ready   = ld_ready;
  assign bus.wb_en      = wb_en_p1;
  assign bus.wb_data    = wb_data_p1;
  assign bus.rd_index   = rd_index_p1;
  assign bus.pend_mask  = pend_mask;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected write-backs are queued with their due cycle
// and a negedge monitor matches every cycle's write port against that queue.
module tb_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  logic    clk = 1'b0;
  logic    rst_n;
  int      cyc = 0;
  int      n_chk = 0;
  int      n_fail = 0;
  bit      mon_en = 1'b0;
  wb_exp_t sb[$];

  wb_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wb(input int c, input logic [4:0] rd, input logic [31:0] data);
    wb_exp_t e;
    e.cyc  = c;
    e.rd   = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic drv_alu(input logic v, input logic [4:0] rd, input logic [31:0] data);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_data  = data;
  endtask

  task automatic drv_ld(input logic v, input logic [4:0] rd, input logic [31:0] data);
    bus.ld_valid = v;
    bus.ld_rd    = rd;
    bus.ld_data  = data;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin : mon
      int idx;
      idx = -1;
      foreach (sb[i]) if (sb[i].cyc == cyc) idx = i;
      if (idx >= 0) begin
        check("wb_en", 64'(bus.wb_en), 64'd1);
        check("rd_index", 64'(bus.rd_index), 64'(sb[idx].rd));
        check("wb_data", 64'(bus.wb_data), 64'(sb[idx].data));
        sb.delete(idx);
      end else begin
        check("wb_idle", 64'(bus.wb_en), 64'd0);
      end
    end
  end

  initial begin
    int n;
    logic [31:0] d;

    // Reset held with both request paths active
    rst_n = 1'b0;
    drv_alu(1'b1, 5'd9, 32'hAAAA_0009);
    drv_ld(1'b1, 5'd9, 32'hBBBB_0009);
    step();
    step();
    @(negedge clk);
    check("rst_ld_ready", 64'(bus.ld_ready), 64'd0);
    check("rst_wb_en", 64'(bus.wb_en), 64'd0);
    check("rst_count", 64'(bus.fifo_count), 64'd0);
    check("rst_pend", 64'(bus.pend_mask), 64'd0);
    check("rst_wb_data", 64'(bus.wb_data), 64'd0);
    check("rst_rd_index", 64'(bus.rd_index), 64'd0);
    step();
    rst_n = 1'b1;
    drv_alu(1'b0, 5'd0, 32'd0);
    drv_ld(1'b0, 5'd0, 32'd0);
    mon_en = 1'b1;
    @(negedge clk);
    check("rel_ld_ready", 64'(bus.ld_ready), 64'd1);
    step();

    // ALU latency, then ALU to x0, then output hold while idle
    n = cyc;
    drv_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
    expect_wb(n + 1, 5'd5, 32'hDEAD_BEEF);
    step();
    drv_alu(1'b1, 5'd0, 32'h1234_5678);
    step();
    drv_alu(1'b0, 5'd0, 32'd0);
    step();
    @(negedge clk);
    check("hold_rd_index", 64'(bus.rd_index), 64'd5);
    check("hold_wb_data", 64'(bus.wb_data), 64'hDEAD_BEEF);
    step();

    // Load behind two ALU results
    n = cyc;
    drv_ld(1'b1, 5'd7, 32'h11);
    expect_wb(n + 4, 5'd7, 32'h11);
    @(negedge clk);
    check("pri_ld_ready", 64'(bus.ld_ready), 64'd1);
    step();
    drv_ld(1'b0, 5'd0, 32'd0);
    drv_alu(1'b1, 5'd3, 32'hA1);
    expect_wb(n + 2, 5'd3, 32'hA1);
    @(negedge clk);
    check("pri_pend_n1", 64'(bus.pend_mask), 64'h80);
    step();
    drv_alu(1'b1, 5'd3, 32'hA2);
    expect_wb(n + 3, 5'd3, 32'hA2);
    @(negedge clk);
    check("pri_pend_n2", 64'(bus.pend_mask), 64'h80);
    step();
    drv_alu(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("pri_pend_n3", 64'(bus.pend_mask), 64'h80);
    step();
    @(negedge clk);
    check("pri_pend_n4", 64'(bus.pend_mask), 64'h0);
    step();
    step();

    // Fill the FIFO behind sustained ALU traffic, then drain
    n = cyc;
    for (int k = 0; k < 5; k++) begin
      drv_alu(1'b1, 5'd10, 32'hC000_0000 + 32'(k));
      expect_wb(n + k + 1, 5'd10, 32'hC000_0000 + 32'(k));
      if (k < 4) drv_ld(1'b1, 5'(k + 1), 32'h100 + 32'(k + 1));
      else       drv_ld(1'b0, 5'd0, 32'd0);
      if (k < 4) expect_wb(n + 6 + k, 5'(k + 1), 32'h100 + 32'(k + 1));
      if (k < 4) begin
        @(negedge clk);
        check("fill_ld_ready", 64'(bus.ld_ready), 64'd1);
      end
      if (k < 4) step();
    end
    @(negedge clk);
    check("full_count", 64'(bus.fifo_count), 64'd4);
    check("full_ld_ready", 64'(bus.ld_ready), 64'd0);
    check("full_pend", 64'(bus.pend_mask), 64'h1E);
    step();
    drv_alu(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("drain0_ld_ready", 64'(bus.ld_ready), 64'd0);
    step();
    @(negedge clk);
    check("drain1_ld_ready", 64'(bus.ld_ready), 64'd1);
    check("drain1_count", 64'(bus.fifo_count), 64'd3);
    repeat (5) step();

    // Ten back-to-back loads through the wrapping pointers, then a load to x0
    n = cyc;
    for (int k = 0; k < 11; k++) begin
      d = $urandom;
      if (k < 10) begin
        drv_ld(1'b1, 5'(11 + k), d);
        expect_wb(n + k + 2, 5'(11 + k), d);
      end else begin
        drv_ld(1'b1, 5'd0, d);
      end
      @(negedge clk);
      check("wrap_ld_ready", 64'(bus.ld_ready), 64'd1);
      check("wrap_count_le1", 64'(bus.fifo_count <= 1), 64'd1);
      step();
    end
    drv_ld(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("wrap_count_end", 64'(bus.fifo_count), 64'd0);
    repeat (3) step();

    // Reset while three loads are queued
    n = cyc;
    for (int k = 0; k < 3; k++) begin
      drv_alu(1'b1, 5'd21, 32'hE000_0000 + 32'(k));
      expect_wb(n + k + 1, 5'd21, 32'hE000_0000 + 32'(k));
      drv_ld(1'b1, 5'(22 + k), 32'h5500 + 32'(k));
      step();
    end
    drv_alu(1'b0, 5'd0, 32'd0);
    drv_ld(1'b0, 5'd0, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_pre_count", 64'(bus.fifo_count), 64'd3);
    check("mid_pre_pend", 64'(bus.pend_mask), 64'h01C0_0000);
    check("mid_ld_ready_low", 64'(bus.ld_ready), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_count", 64'(bus.fifo_count), 64'd0);
    check("mid_pend", 64'(bus.pend_mask), 64'h0);
    check("mid_ld_ready", 64'(bus.ld_ready), 64'd1);
    repeat (6) step();
    @(negedge clk);

    check("sb_empty", 64'(sb.size()), 64'd0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
